// File: rtl/m6502_bus_pkg.sv
// m6502_bus_pkg: shared types and constants for the m6502 bus responder
package m6502_bus_pkg;
  typedef enum logic [1:0] {RG_RAM, RG_IO, RG_VEC, RG_NONE} region_e;
  typedef enum logic {S_IDLE, S_WAIT} state_e;
  localparam logic [7:0] IO_BASE      = 8'hD0;
  localparam logic [7:0] OPEN_BUS     = 8'hFF;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h00;
  localparam logic [7:0] OFF_IRQ_EN   = 8'h01;
  localparam logic [7:0] OFF_NMI_TRIG = 8'h02;
  localparam logic [7:0] OFF_TMR      = 8'h03;
  localparam logic [7:0] OFF_SCRATCH  = 8'h04;
  function automatic logic [7:0] vec_byte(input logic [2:0] a, input logic [15:0] nmi_v,
                                          input logic [15:0] rst_v, input logic [15:0] irq_v);
    logic [15:0] w;
    w = (a[2:1] == 2'b01) ? nmi_v : (a[2:1] == 2'b10) ? rst_v : irq_v;
    return a[0] ? w[15:8] : w[7:0];
  endfunction
endpackage

// File: rtl/m6502_ram.sv
// m6502_ram: single-port RAM with synchronous write and asynchronous read
module m6502_ram #(
  parameter int AW = 11
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];
  always_ff @(posedge clk_i)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/m6502_bus_resp.sv
// m6502_bus_resp: m6502 bus target (RAM, IO page, vectors, wait states, IRQ/NMI); M6502_BUS_TIMER_EN adds the IO timer
module m6502_bus_resp
  import m6502_bus_pkg::*;
#(
  parameter int          RAM_AW    = 11,
  parameter int          RAM_WS    = 0,
  parameter int          IO_WS     = 2,
  parameter int          ROM_WS    = 1,
  parameter int          NMI_PULSE = 4,
  parameter logic [15:0] NMI_VEC   = 16'hE100,
  parameter logic [15:0] RST_VEC   = 16'hE000,
  parameter logic [15:0] IRQ_VEC   = 16'hE200
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        we_n_i,
  output logic [7:0]  cpu_din_o,
  output logic        rdy_o,
  output logic        irq_n_o,
  output logic        nmi_n_o,
  input  logic [3:0]  ext_irq_i,
  input  logic        ext_nmi_i
);
  localparam int WS12  = RAM_WS > IO_WS ? RAM_WS : IO_WS;
  localparam int WSMAX = WS12 > ROM_WS ? WS12 : ROM_WS;
  localparam int WCW   = WSMAX > 0 ? $clog2(WSMAX + 1) : 1;
  localparam int NCW   = $clog2(NMI_PULSE + 1);
  region_e        rg;
  state_e         state_q, state_d;
  logic [WCW-1:0] ws, wcnt_q, wcnt_d;
  logic [NCW-1:0] nmi_cnt_q, nmi_cnt_d;
  logic [4:0]     irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
  logic [3:0]     ext_irq_q;
  logic           ext_nmi_q, irq_n_q, irq_n_d, rdy_int, commit, io_wr, nmi_evt, tmr_evt;
  logic [7:0]     off, scratch_q, ram_rd, io_rd, tmr_rd;
  always_comb begin
    rg = ((addr_i >> RAM_AW) == 16'd0) ? RG_RAM :
         (addr_i[15:8] == IO_BASE)     ? RG_IO  :
         (addr_i >= 16'hFFFA)          ? RG_VEC : RG_NONE;
    ws = (rg == RG_RAM) ? WCW'(RAM_WS) : (rg == RG_IO) ? WCW'(IO_WS) :
         (rg == RG_VEC) ? WCW'(ROM_WS) : '0;
    off = addr_i[7:0];
    rdy_int = (state_q == S_IDLE) ? (ws == '0) : (wcnt_q == '0);
    state_d = rdy_int ? S_IDLE : S_WAIT;
    wcnt_d = (state_q == S_IDLE) ? ((ws == '0) ? '0 : ws - WCW'(1))
                                 : ((wcnt_q == '0) ? '0 : wcnt_q - WCW'(1));
    rdy_o = reset_i | rdy_int;
    // reset abandons any in-flight access, so no write may commit while it is held
    commit = rdy_int & ~we_n_i & ~reset_i;
    io_wr = commit && rg == RG_IO;
    irq_stat_d = (irq_stat_q & ~((io_wr && off == OFF_IRQ_STAT) ? cpu_dout_i[4:0] : 5'd0))
                 | {tmr_evt, ext_irq_i & ~ext_irq_q};
    irq_en_d = (io_wr && off == OFF_IRQ_EN) ? cpu_dout_i[4:0] : irq_en_q;
    irq_n_d = ~|(irq_stat_q & irq_en_q);
    nmi_evt = (io_wr && off == OFF_NMI_TRIG) | (ext_nmi_i & ~ext_nmi_q);
    nmi_cnt_d = nmi_evt ? NCW'(NMI_PULSE) : (nmi_cnt_q == '0) ? '0 : nmi_cnt_q - NCW'(1);
    io_rd = (off == OFF_IRQ_STAT) ? {3'b0, irq_stat_q} :
            (off == OFF_IRQ_EN)   ? {3'b0, irq_en_q}   :
            (off == OFF_TMR)      ? tmr_rd             :
            (off == OFF_SCRATCH)  ? scratch_q          : 8'h00;
    cpu_din_o = reset_i        ? OPEN_BUS :
                (rg == RG_RAM) ? ram_rd   :
                (rg == RG_IO)  ? io_rd    :
                (rg == RG_VEC) ? vec_byte(addr_i[2:0], NMI_VEC, RST_VEC, IRQ_VEC) : OPEN_BUS;
    irq_n_o = irq_n_q;
    nmi_n_o = (nmi_cnt_q == '0);
  end
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      nmi_cnt_q  <= '0;
      ext_irq_q  <= '0;
      ext_nmi_q  <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      irq_stat_q <= irq_stat_d;
      irq_en_q   <= irq_en_d;
      nmi_cnt_q  <= nmi_cnt_d;
      ext_irq_q  <= ext_irq_i;
      ext_nmi_q  <= ext_nmi_i;
      irq_n_q    <= irq_n_d;
    end
  always_ff @(posedge clk_i)
    if (io_wr && off == OFF_SCRATCH) scratch_q <= cpu_dout_i;
`ifdef M6502_BUS_TIMER_EN
  logic [7:0] tmr_rel_q, tmr_cnt_q;
  logic       tmr_wr;
  assign tmr_wr  = io_wr && off == OFF_TMR;
  assign tmr_evt = !tmr_wr && tmr_rel_q != 8'd0 && tmr_cnt_q == 8'd1;
  assign tmr_rd  = tmr_rel_q;
  always_ff @(posedge clk_i or posedge reset_i)
    if (reset_i) begin
      tmr_rel_q <= '0;
      tmr_cnt_q <= '0;
    end else if (tmr_wr) begin
      tmr_rel_q <= cpu_dout_i;
      tmr_cnt_q <= cpu_dout_i;
    end else if (tmr_rel_q != 8'd0) begin
      tmr_cnt_q <= (tmr_cnt_q <= 8'd1) ? tmr_rel_q : tmr_cnt_q - 8'd1;
    end
`else
  assign tmr_evt = 1'b0;
  assign tmr_rd  = 8'h00;
`endif
  m6502_ram #(.AW(RAM_AW)) u_ram (
    .clk_i  (clk_i),
    .we_i   (commit && rg == RG_RAM),
    .addr_i (addr_i[RAM_AW-1:0]),
    .wdata_i(cpu_dout_i),
    .rdata_o(ram_rd)
  );
endmodule

// File: tb/tb_m6502_bus_resp.sv
// tb_m6502_bus_resp: directed scoreboard bench for the m6502 bus responder
module tb_m6502_bus_resp;
  logic        clk = 1'b0, reset = 1'b1, we_n = 1'b1, ext_nmi = 1'b0;
  logic [15:0] addr = 16'hD004;
  logic [7:0]  dout = 8'h00, din;
  logic [3:0]  ext_irq = 4'h0;
  logic        rdy, irq_n, nmi_n;
  logic [7:0]  sb[$];
  int          total = 0, bad = 0;

  m6502_bus_resp dut (
    .clk_i(clk), .reset_i(reset), .addr_i(addr), .cpu_dout_i(dout), .we_n_i(we_n),
    .cpu_din_o(din), .rdy_o(rdy), .irq_n_o(irq_n), .nmi_n_o(nmi_n),
    .ext_irq_i(ext_irq), .ext_nmi_i(ext_nmi)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // one CPU access; reads push the expected byte and pop it when rdy is seen
  task automatic acc(input string tag, input logic [15:0] a, input logic w, input logic [7:0] d,
                     input int ws, input logic [7:0] exp);
    int n = 0;
    addr = a; we_n = w; dout = d;
    if (w) sb.push_back(exp);
    @(negedge clk);
    while (!rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_ws"}, 16'(n), 16'(ws));
    if (w) chk({tag, "_rd"}, {8'h0, din}, {8'h0, sb.pop_front()});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    addr = 16'h8000; we_n = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state, with an IO address presented to show rdy is forced
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", {15'h0, rdy}, 16'h1);
    chk("rst_irq_n", {15'h0, irq_n}, 16'h1);
    chk("rst_nmi_n", {15'h0, nmi_n}, 16'h1);
    chk("rst_din", {8'h0, din}, 16'h00FF);
    @(posedge clk); #1;
    reset = 1'b0;
    // RAM, zero wait states, and its top boundary
    acc("ram_wr", 16'h0010, 1'b0, 8'h5A, 0, 8'h00);
    acc("ram_rd", 16'h0010, 1'b1, 8'h00, 0, 8'h5A);
    acc("ram_top_wr", 16'h07FF, 1'b0, 8'hA5, 0, 8'h00);
    acc("ram_top_rd", 16'h07FF, 1'b1, 8'h00, 0, 8'hA5);
    acc("ram_past", 16'h0800, 1'b1, 8'h00, 0, 8'hFF);
    // IO scratch with two wait states
    acc("scr_wr", 16'hD004, 1'b0, 8'h33, 2, 8'h00);
    acc("scr_rd", 16'hD004, 1'b1, 8'h00, 2, 8'h33);
    acc("io_unl", 16'hD07F, 1'b1, 8'h00, 2, 8'h00);
    acc("nmi_rd", 16'hD002, 1'b1, 8'h00, 2, 8'h00);
`ifndef M6502_BUS_TIMER_EN
    acc("tmr_wr_x", 16'hD003, 1'b0, 8'h05, 2, 8'h00);
    acc("tmr_rd_x", 16'hD003, 1'b1, 8'h00, 2, 8'h00);
`endif
    // vectors and open bus
    acc("vec_fffa", 16'hFFFA, 1'b1, 8'h00, 1, 8'h00);
    acc("vec_fffb", 16'hFFFB, 1'b1, 8'h00, 1, 8'hE1);
    acc("vec_fffc", 16'hFFFC, 1'b1, 8'h00, 1, 8'h00);
    acc("vec_fffd", 16'hFFFD, 1'b1, 8'h00, 1, 8'hE0);
    acc("vec_ffff", 16'hFFFF, 1'b1, 8'h00, 1, 8'hE2);
    acc("vec_wr", 16'hFFFC, 1'b0, 8'h12, 1, 8'h00);
    acc("vec_fffc2", 16'hFFFC, 1'b1, 8'h00, 1, 8'h00);
    acc("open", 16'h8000, 1'b1, 8'h00, 0, 8'hFF);
    // interrupt status, enable and write-1-to-clear
    acc("en_wr", 16'hD001, 1'b0, 8'h01, 2, 8'h00);
    chk("irq_n_idle", {15'h0, irq_n}, 16'h1);
    ext_irq[0] = 1'b1;
    idle(3);
    chk("irq_n_set", {15'h0, irq_n}, 16'h0);
    acc("stat_rd", 16'hD000, 1'b1, 8'h00, 2, 8'h01);
    acc("w1c", 16'hD000, 1'b0, 8'h01, 2, 8'h00);
    idle(1);
    chk("irq_n_clr", {15'h0, irq_n}, 16'h1);
    acc("stat_clr", 16'hD000, 1'b1, 8'h00, 2, 8'h00);
    // rising edge on ext_irq[1] lands on the same edge as a W1C of that bit
    addr = 16'hD000; we_n = 1'b0; dout = 8'h02;
    repeat (2) @(posedge clk);
    #1 ext_irq[1] = 1'b1;
    @(negedge clk);
    chk("w1c_race_rdy", {15'h0, rdy}, 16'h1);
    @(posedge clk); #1;
    acc("set_wins", 16'hD000, 1'b1, 8'h00, 2, 8'h02);
    // NMI pulse from a register write
    acc("nmi_trig", 16'hD002, 1'b0, 8'h99, 2, 8'h00);
    addr = 16'h8000; we_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("nmi_pulse%0d", k), {15'h0, nmi_n}, (k < 4) ? 16'h0 : 16'h1);
    end
    @(posedge clk); #1;
    // second trigger, extended by an external edge in cycle 2
    acc("nmi_trig2", 16'hD002, 1'b0, 8'h00, 2, 8'h00);
    addr = 16'h8000; we_n = 1'b1;
    @(negedge clk);
    chk("nmi_ext_c1", {15'h0, nmi_n}, 16'h0);
    @(posedge clk); #1 ext_nmi = 1'b1;
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("nmi_ext_c%0d", c), {15'h0, nmi_n}, (c <= 6) ? 16'h0 : 16'h1);
    end
    @(posedge clk); #1;
    ext_nmi = 1'b0; ext_irq = 4'h0;
    idle(2);
    // reset in the middle of a waited write abandons it
    addr = 16'hD004; we_n = 1'b0; dout = 8'h77;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("midrst_rdy", {15'h0, rdy}, 16'h1);
    @(posedge clk); #1 reset = 1'b0;
    acc("midrst_scr", 16'hD004, 1'b1, 8'h00, 2, 8'h33);
    acc("midrst_stat", 16'hD000, 1'b1, 8'h00, 2, 8'h00);
    acc("midrst_en", 16'hD001, 1'b1, 8'h00, 2, 8'h00);
    chk("midrst_irq_n", {15'h0, irq_n}, 16'h1);
`ifdef M6502_BUS_TIMER_EN
    // timer with reload 3: first status read lands just before the expiry edge
    acc("tmr_wr", 16'hD003, 1'b0, 8'h03, 2, 8'h00);
    acc("tmr_st0", 16'hD000, 1'b1, 8'h00, 2, 8'h00);
    acc("tmr_st1", 16'hD000, 1'b1, 8'h00, 2, 8'h10);
    acc("tmr_rel", 16'hD003, 1'b1, 8'h00, 2, 8'h03);
    acc("tmr_off", 16'hD003, 1'b0, 8'h00, 2, 8'h00);
    acc("tmr_w1c", 16'hD000, 1'b0, 8'h10, 2, 8'h00);
    acc("tmr_st2", 16'hD000, 1'b1, 8'h00, 2, 8'h00);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
